// File: rtl/dense_seq_ctrl.sv
// Sequencing controller for the serial dense stage: clears the accumulators, paces a feature
// vector into the stage, waits (bounded) for its result strobe and holds it on valid/ready.
module dense_seq_ctrl #(
    parameter int unsigned D          = 64,
    parameter int unsigned B          = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ISSUE_GAP  = 2,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned AW         = (D <= 2) ? 1 : $clog2(D)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       feat_rd_o,
    output logic [AW-1:0]              feat_addr_o,
    input  logic [DATA_WIDTH-1:0]      feat_data_i,
    output logic                       acc_clr_o,
    output logic                       dense_valid_o,
    output logic [DATA_WIDTH-1:0]      dense_data_o,
    input  logic                       dense_valid_i,
    input  logic [DATA_WIDTH*B-1:0]    dense_data_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [DATA_WIDTH*B-1:0]    res_data_o,
    output logic                       err_o
);

    localparam int unsigned Gap = (ISSUE_GAP < 2) ? 2 : ISSUE_GAP;
    localparam int unsigned Tmo = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int unsigned GW  = $clog2(Gap);
    localparam int unsigned TW  = (Tmo < 2) ? 1 : $clog2(Tmo);

    localparam logic [GW-1:0] GapLast = GW'(Gap - 1);
    localparam logic [AW-1:0] IdxLast = AW'(D - 1);
    localparam logic [TW-1:0] TmoLast = TW'(Tmo - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StHold
    } state_e;

    state_e                    state_q, state_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [GW-1:0]             gap_q, gap_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH*B-1:0]   res_data_q, res_data_d;
    logic                      rd_pipe_q;
    logic                      dv_q;
    logic [DATA_WIDTH-1:0]     dd_q;
    logic                      feat_rd;
    logic                      acc_clr;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        res_data_d = res_data_q;
        feat_rd    = 1'b0;
        acc_clr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StClear;
                    err_d   = 1'b0;
                end
            end
            StClear: begin
                acc_clr = 1'b1;
                idx_d   = '0;
                gap_d   = '0;
                state_d = StFeed;
            end
            StFeed: begin
                feat_rd = (gap_q == '0);
                gap_d   = (gap_q == GapLast) ? '0 : gap_q + GW'(1);
                if (feat_rd) begin
                    if (idx_q == IdxLast) begin
                        state_d = StDrain;
                        tmo_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            StDrain: begin
                if (dense_valid_i) begin
                    res_data_d = dense_data_i;
                    state_d    = StHold;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StHold: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A result strobe is only legitimate while draining; anywhere else it is flagged.
        if (dense_valid_i && (state_q != StDrain)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            res_data_q <= res_data_d;
        end
    end

    // Element path: read at t, buffer data valid at t+1, registered strobe to the stage at t+2.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_pipe_q <= 1'b0;
            dv_q      <= 1'b0;
            dd_q      <= '0;
        end else begin
            rd_pipe_q <= feat_rd;
            dv_q      <= rd_pipe_q;
            if (rd_pipe_q) begin
                dd_q <= feat_data_i;
            end
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign acc_clr_o     = acc_clr;
    assign feat_rd_o     = feat_rd;
    assign feat_addr_o   = feat_rd ? idx_q : '0;
    assign dense_valid_o = dv_q;
    assign dense_data_o  = dd_q;
    assign res_valid_o   = (state_q == StHold);
    assign res_data_o    = res_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Bench for dense_seq_ctrl: cycle-indexed timing model checked every cycle, plus directed
// scenarios with literal expectations and a randomised phase.
module tb_dense_seq_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned B  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned G  = 2;
    localparam int unsigned TO = 16;
    localparam int unsigned AW = 2;
    localparam int TE  = 3 + (D - 1) * G;           // cycles after start of first DRAIN cycle
    localparam int LAT = 1 + 1 + (D - 1) * G + 1 + 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start_i = 1'b0;
    logic              busy_o;
    logic              feat_rd_o;
    logic [AW-1:0]     feat_addr_o;
    logic [DW-1:0]     feat_data_i;
    logic              acc_clr_o;
    logic              dense_valid_o;
    logic [DW-1:0]     dense_data_o;
    logic              dense_valid_i = 1'b0;
    logic [DW*B-1:0]   dense_data_i = '0;
    logic              res_valid_o;
    logic              res_ready_i = 1'b0;
    logic [DW*B-1:0]   res_data_o;
    logic              err_o;

    always #5 clk = ~clk;

    dense_seq_ctrl #(
        .D(D), .B(B), .DATA_WIDTH(DW), .ISSUE_GAP(G), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .busy_o(busy_o),
        .feat_rd_o(feat_rd_o), .feat_addr_o(feat_addr_o), .feat_data_i(feat_data_i),
        .acc_clr_o(acc_clr_o), .dense_valid_o(dense_valid_o), .dense_data_o(dense_data_o),
        .dense_valid_i(dense_valid_i), .dense_data_i(dense_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .err_o(err_o)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Feature buffer with one cycle of read latency.
    logic [DW-1:0] mem [D];
    logic [DW-1:0] buf_q = '0;
    always @(posedge clk) if (feat_rd_o) buf_q <= mem[feat_addr_o];
    assign feat_data_i = buf_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: inference progress is a cycle index t since start acceptance.
    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } strobe_t;
    strobe_t dvq[$];
    bit m_act = 0, m_hold = 0, m_err = 0;
    int m_t = 0;
    logic [DW*B-1:0] m_rdata = '0;
    bit e_busy, e_clr, e_rd, e_dv, e_rv, e_err;
    int e_addr;
    logic [DW-1:0] e_dd;

    function automatic bit reads_at(bit act, bit hold, int t);
        return act && !hold && t >= 2 && ((t - 2) % G) == 0 && ((t - 2) / G) < D;
    endfunction

    always @(posedge clk) begin
        bit in_drain;
        if (!rstn) begin
            m_act = 0; m_hold = 0; m_err = 0; m_t = 0; m_rdata = '0;
            dvq.delete();
        end else begin
            if (reads_at(m_act, m_hold, m_t))
                dvq.push_back('{due: cyc + 2, data: mem[(m_t - 2) / G]});
            in_drain = m_act && !m_hold && m_t >= TE;
            if (!m_act) begin
                if (start_i) begin m_act = 1; m_t = 1; m_err = 0; end
            end else if (m_hold) begin
                if (res_ready_i) begin m_act = 0; m_hold = 0; end
            end else if (in_drain) begin
                if (dense_valid_i) begin m_hold = 1; m_rdata = dense_data_i; end
                else if (m_t - TE == TO - 1) begin m_act = 0; m_err = 1; end
                else m_t++;
            end else begin
                m_t++;
            end
            if (dense_valid_i && !in_drain) m_err = 1;
        end
        cyc++;
        e_busy = m_act;
        e_clr  = m_act && m_t == 1;
        e_rd   = reads_at(m_act, m_hold, m_t);
        e_addr = (m_t - 2) / G;
        e_rv   = m_hold;
        e_err  = m_err;
        e_dv   = 0;
        if (dvq.size() > 0 && dvq[0].due == cyc) begin
            e_dv = 1;
            e_dd = dvq[0].data;
            void'(dvq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", busy_o, e_busy);
            chk("acc_clr", acc_clr_o, e_clr);
            chk("feat_rd", feat_rd_o, e_rd);
            if (e_rd) chk("feat_addr", feat_addr_o, e_addr);
            chk("dense_valid", dense_valid_o, e_dv);
            if (e_dv) chk("dense_data", dense_data_o, e_dd);
            chk("res_valid", res_valid_o, e_rv);
            chk("res_data", res_data_o, m_rdata);
            chk("err", err_o, e_err);
        end
    end

    // Dense-stage stand-in: answers 2 cycles after the D-th element strobe of an inference.
    int stub_cnt = 0;
    int stub_due = -1;
    bit stub_mute = 0;
    logic [DW*B-1:0] stub_res = '0;
    int clr_cnt = 0;
    int rd_addr[$];
    int rd_cyc[$];
    logic [DW-1:0] dv_log[$];

    task automatic tick();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        dense_valid_i = 1'b0;
        dense_data_i = 16'($urandom);
        if (acc_clr_o) begin stub_cnt = 0; clr_cnt++; end
        if (feat_rd_o) begin rd_addr.push_back(int'(feat_addr_o)); rd_cyc.push_back(cyc); end
        if (dense_valid_o) begin
            dv_log.push_back(dense_data_o);
            stub_cnt++;
            if (stub_cnt == D && !stub_mute) stub_due = cyc + 2;
        end
        if (stub_due == cyc) begin
            dense_valid_i = 1'b1;
            dense_data_i = stub_res;
            stub_due = -1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        stub_due = -1;
        stub_cnt = 0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic clear_logs();
        clr_cnt = 0;
        rd_addr.delete();
        rd_cyc.delete();
        dv_log.delete();
    endtask

    // want_rv=1: until res_valid_o; want_rv=0: until busy_o drops. Budget overrun is a failure.
    task automatic wait_for(input bit want_rv, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (want_rv ? res_valid_o : !busy_o) begin
                at = cyc;
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL wait_budget: got no event want event within %0d cycles", budget);
    endtask

    task automatic handshake();
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
    endtask

    task automatic check_feed(input string tag);
        logic [DW-1:0] exp_dv [4];
        exp_dv = '{8'h01, 8'hFE, 8'h03, 8'h04};
        chk({tag, "_clr_cnt"}, clr_cnt, 1);
        chk({tag, "_nreads"}, rd_addr.size(), D);
        for (int k = 0; k < rd_addr.size(); k++) chk({tag, "_addr"}, rd_addr[k], k);
        for (int k = 1; k < rd_cyc.size(); k++) chk({tag, "_gap"}, rd_cyc[k] - rd_cyc[k-1], G);
        chk({tag, "_ndv"}, dv_log.size(), D);
        for (int k = 0; k < dv_log.size() && k < 4; k++) chk({tag, "_dv_data"}, dv_log[k], exp_dv[k]);
    endtask

    initial begin
        int s, at;
        mem[0] = 8'd1; mem[1] = 8'hFE; mem[2] = 8'd3; mem[3] = 8'd4;
        stub_res = 16'h05FB;
        do_reset();
        tick();

        // Nominal inference with literal timing and data.
        clear_logs();
        start_i = 1'b1; s = cyc; tick();
        wait_for(1, 100, at);
        chk("t1_latency", at - s, LAT);
        chk("t1_first_read", rd_cyc.size() > 0 ? rd_cyc[0] - s : -1, 2);
        check_feed("t1");
        chk("t1_res", res_data_o, 16'h05FB);
        handshake();
        chk("t1_busy_after", busy_o, 0);
        chk("t1_rv_after", res_valid_o, 0);
        chk("t1_res_kept", res_data_o, 16'h05FB);

        // Back-pressure for 10 cycles, accepted on the 11th.
        start_i = 1'b1; tick();
        wait_for(1, 100, at);
        for (int i = 0; i < 10; i++) begin
            chk("t2_rv_hold", res_valid_o, 1);
            chk("t2_res_hold", res_data_o, 16'h05FB);
            tick();
        end
        handshake();
        chk("t2_busy_after", busy_o, 0);

        // Dense stage never answers.
        stub_mute = 1;
        start_i = 1'b1; s = cyc; tick();
        wait_for(0, 100, at);
        chk("t3_timeout_at", at - s, TE + TO);
        chk("t3_err", err_o, 1);
        chk("t3_rv", res_valid_o, 0);
        stub_mute = 0;
        start_i = 1'b1; tick();
        chk("t3_err_cleared", err_o, 0);
        wait_for(1, 100, at);
        handshake();

        // start_i during FEED and together with the HOLD handshake is ignored.
        clear_logs();
        start_i = 1'b1; s = cyc; tick();
        while (cyc < s + 5) tick();
        start_i = 1'b1; tick();
        wait_for(1, 100, at);
        start_i = 1'b1;
        handshake();
        chk("t4_busy_t1", busy_o, 0);
        tick();
        chk("t4_busy_t2", busy_o, 0);
        check_feed("t4");

        // Stray result strobe during FEED.
        clear_logs();
        start_i = 1'b1; s = cyc; tick();
        while (cyc < s + 5) tick();
        dense_valid_i = 1'b1; dense_data_i = 16'hA5A5; tick();
        chk("t5_err", err_o, 1);
        wait_for(1, 100, at);
        check_feed("t5");
        chk("t5_res", res_data_o, 16'h05FB);
        handshake();
        chk("t5_err_sticky", err_o, 1);

        // Reset while reading idx 2, then a clean restart.
        start_i = 1'b1; tick();
        for (int i = 0; i < 50 && !(feat_rd_o && feat_addr_o == 2'd2); i++) tick();
        chk("t6_reached_idx2", feat_addr_o, 2);
        do_reset();
        chk("t6_busy", busy_o, 0);
        chk("t6_clr", acc_clr_o, 0);
        chk("t6_rd", feat_rd_o, 0);
        chk("t6_dv", dense_valid_o, 0);
        chk("t6_dd", dense_data_o, 0);
        chk("t6_rv", res_valid_o, 0);
        chk("t6_res", res_data_o, 0);
        chk("t6_err", err_o, 0);
        start_i = 1'b1; tick();
        chk("t6_reclear", acc_clr_o, 1);
        tick();
        chk("t6_rd0", feat_rd_o, 1);
        chk("t6_addr0", feat_addr_o, 0);
        wait_for(1, 100, at);
        handshake();

        // Randomised inferences against the model.
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < D; k++) mem[k] = 8'($urandom);
            stub_res = 16'($urandom);
            stub_mute = ($urandom_range(0, 7) == 0);
            start_i = 1'b1; tick();
            for (int c = 0; c < 200 && busy_o; c++) begin
                res_ready_i = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 29) == 0) start_i = 1'b1;
                if ($urandom_range(0, 39) == 0) begin
                    dense_valid_i = 1'b1;
                    dense_data_i = 16'($urandom);
                end
                if ($urandom_range(0, 199) == 0) do_reset();
                else tick();
            end
            res_ready_i = 1'b0;
            if (busy_o) begin
                total++;
                bad++;
                $display("FAIL rand_budget: got busy want idle within 200 cycles");
            end
            for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
                if ($urandom_range(0, 9) == 0) dense_valid_i = 1'b1;
                tick();
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
